// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: latches decoded fields on a valid/ready handshake
// and forwards MEM/WB results onto the ALU operands.
module id_ex_operand_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alusrc,
  input  logic [2:0]      id_aluctrl,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic            id_regwrite,
  input  logic            id_branch,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic            mem_regwrite,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] ALUop1,
  output logic [XLEN-1:0] ALUop2,
  output logic [2:0]      ALUctrl,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_regwrite,
  output logic            ex_branch
);

  logic [RA_W-1:0] rs1_addr_q, rs2_addr_q;
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic            alusrc_q, regwrite_q, branch_q;
  logic [XLEN-1:0] fwd1, fwd2;
  logic            accept;

  assign id_ready = rst_n & (~ex_valid | ex_ready);
  assign accept   = id_valid & id_ready;

  // MEM is younger than WB, so it wins when both target the same register.
  always_comb begin
    fwd1 = rs1_data_q;
    if (rs1_addr_q != '0 && mem_regwrite && mem_rd_addr == rs1_addr_q)
      fwd1 = mem_result;
    else if (rs1_addr_q != '0 && wb_regwrite && wb_rd_addr == rs1_addr_q)
      fwd1 = wb_result;
  end

  always_comb begin
    fwd2 = rs2_data_q;
    if (rs2_addr_q != '0 && mem_regwrite && mem_rd_addr == rs2_addr_q)
      fwd2 = mem_result;
    else if (rs2_addr_q != '0 && wb_regwrite && wb_rd_addr == rs2_addr_q)
      fwd2 = wb_result;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      ALUctrl    <= '0;
      ex_rd_addr <= '0;
      regwrite_q <= 1'b0;
      branch_q   <= 1'b0;
    end else begin
      ex_valid <= ~flush & (accept | (ex_valid & ~ex_ready));
      if (accept) begin
        rs1_addr_q <= id_rs1_addr;
        rs2_addr_q <= id_rs2_addr;
        rs1_data_q <= id_rs1_data;
        rs2_data_q <= id_rs2_data;
        imm_q      <= id_imm;
        alusrc_q   <= id_alusrc;
        ALUctrl    <= id_aluctrl;
        ex_rd_addr <= id_rd_addr;
        regwrite_q <= id_regwrite;
        branch_q   <= id_branch;
      end else begin
        // Capture forwarded values every cycle so a producer retiring from
        // WB during a stall is still seen once it leaves the pipeline.
        rs1_data_q <= fwd1;
        rs2_data_q <= fwd2;
      end
    end
  end

  assign ALUop1        = fwd1;
  assign ALUop2        = alusrc_q ? imm_q : fwd2;
  assign ex_store_data = fwd2;
  assign ex_regwrite   = ex_valid & regwrite_q;
  assign ex_branch     = ex_valid & branch_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: a driver pushes the expected
// per-cycle view of the held instruction; a monitor pops and compares.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, id_ready, id_alusrc, id_regwrite, id_branch;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [2:0]  id_aluctrl;
  logic        flush, ex_ready;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_regwrite, wb_regwrite;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid, ex_regwrite, ex_branch;
  logic [31:0] ALUop1, ALUop2, ex_store_data;
  logic [2:0]  ALUctrl;
  logic [4:0]  ex_rd_addr;

  id_ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_aluctrl(id_aluctrl), .id_rd_addr(id_rd_addr),
    .id_regwrite(id_regwrite), .id_branch(id_branch), .flush(flush),
    .ex_ready(ex_ready), .mem_rd_addr(mem_rd_addr), .mem_regwrite(mem_regwrite),
    .mem_result(mem_result), .wb_rd_addr(wb_rd_addr), .wb_regwrite(wb_regwrite),
    .wb_result(wb_result), .ex_valid(ex_valid), .ALUop1(ALUop1), .ALUop2(ALUop2),
    .ALUctrl(ALUctrl), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_regwrite(ex_regwrite), .ex_branch(ex_branch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk_ready, chk_state, chk_data;
    logic        ready, valid, rw, br;
    logic [31:0] op1, op2, sd;
    logic [2:0]  ctrl;
    logic [4:0]  rd;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;

  // Reference model: the instruction currently held by the stage, with the
  // source values it would read right now.
  logic        m_known = 1'b0, m_zero = 1'b0, m_valid = 1'b0;
  logic [4:0]  m_rs1a, m_rs2a, m_rd;
  logic [31:0] m_rs1d, m_rs2d, m_imm;
  logic        m_alusrc, m_rw, m_br;
  logic [2:0]  m_ctrl;

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (a != 0 && mem_regwrite && mem_rd_addr == a) return mem_result;
    if (a != 0 && wb_regwrite && wb_rd_addr == a) return wb_result;
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    logic accept, rdy;
    rdy         = rst_n && (!m_valid || ex_ready);
    e.chk_ready = m_known || !rst_n;
    e.chk_state = m_known;
    e.chk_data  = m_known && (m_valid || m_zero);
    e.ready = rdy;
    e.valid = m_valid;
    e.rw    = m_valid && m_rw;
    e.br    = m_valid && m_br;
    e.op1   = fwd(m_rs1a, m_rs1d);
    e.sd    = fwd(m_rs2a, m_rs2d);
    e.op2   = m_alusrc ? m_imm : e.sd;
    e.ctrl  = m_ctrl;
    e.rd    = m_rd;
    q.push_back(e);
    @(posedge clk);
    if (!rst_n) begin
      m_known = 1'b1; m_zero = 1'b1; m_valid = 1'b0;
      m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
      m_alusrc = 0; m_rw = 0; m_br = 0; m_ctrl = 0;
    end else begin
      accept = id_valid && rdy;
      if (accept) begin
        m_zero = 1'b0;
        m_rs1a = id_rs1_addr; m_rs2a = id_rs2_addr;
        m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
        m_alusrc = id_alusrc; m_ctrl = id_aluctrl; m_rd = id_rd_addr;
        m_rw = id_regwrite; m_br = id_branch;
      end else begin
        m_rs1d = fwd(m_rs1a, m_rs1d);
        m_rs2d = fwd(m_rs2a, m_rs2d);
      end
      m_valid = !flush && (accept || (m_valid && !ex_ready));
    end
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1a, input logic [31:0] r1d,
                        input logic [4:0] r2a, input logic [31:0] r2d, input logic [31:0] imm,
                        input logic src, input logic [2:0] ctrl, input logic [4:0] rd,
                        input logic rw, input logic br);
    id_valid = v; id_rs1_addr = r1a; id_rs1_data = r1d; id_rs2_addr = r2a;
    id_rs2_data = r2d; id_imm = imm; id_alusrc = src; id_aluctrl = ctrl;
    id_rd_addr = rd; id_regwrite = rw; id_branch = br;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_ready) chk("id_ready", 32'(id_ready), 32'(e.ready));
        if (e.chk_state) begin
          chk("ex_valid", 32'(ex_valid), 32'(e.valid));
          chk("ex_regwrite", 32'(ex_regwrite), 32'(e.rw));
          chk("ex_branch", 32'(ex_branch), 32'(e.br));
        end
        if (e.chk_data) begin
          chk("ALUop1", ALUop1, e.op1);
          chk("ALUop2", ALUop2, e.op2);
          chk("ex_store_data", ex_store_data, e.sd);
          chk("ALUctrl", 32'(ALUctrl), 32'(e.ctrl));
          chk("ex_rd_addr", 32'(ex_rd_addr), 32'(e.rd));
        end
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    mem_rd_addr = 0; mem_regwrite = 0; mem_result = 0;
    wb_rd_addr = 0; wb_regwrite = 0; wb_result = 0;
    set_id(1, 1, 32'h1, 2, 32'h2, 32'h3, 0, 3'b000, 5, 1, 0);
    @(posedge clk); #1;

    // Reset held with id_valid high, then release.
    step(); step();
    rst_n = 1'b1; step();

    // Basic pass with immediate operand.
    set_id(1, 1, 32'd5, 2, 32'd9, 32'd7, 1, 3'b000, 6, 1, 0);
    step();
    id_valid = 0; step();

    // Forward priority MEM over WB, then WB alone.
    set_id(1, 3, 32'd1, 4, 32'd2, 32'd0, 0, 3'b000, 3, 1, 0);
    step();
    id_valid = 0; ex_ready = 0;
    mem_rd_addr = 3; mem_regwrite = 1; mem_result = 32'h20;
    wb_rd_addr = 3; wb_regwrite = 1; wb_result = 32'h30;
    step();
    mem_regwrite = 0; step();
    wb_regwrite = 0; ex_ready = 1; step();

    // Register 0 is never forwarded.
    set_id(1, 0, 32'h11, 0, 32'h22, 32'd0, 0, 3'b000, 1, 1, 0);
    step();
    id_valid = 0; ex_ready = 0;
    mem_rd_addr = 0; mem_regwrite = 1; mem_result = 32'd9;
    step();
    mem_regwrite = 0; ex_ready = 1; step();

    // WB producer retiring during a stall must persist.
    set_id(1, 1, 32'd0, 4, 32'd0, 32'd0, 0, 3'b000, 2, 1, 0);
    step();
    id_valid = 0; ex_ready = 0;
    wb_rd_addr = 4; wb_regwrite = 1; wb_result = 32'h55;
    step();
    wb_regwrite = 0;
    repeat (3) step();
    ex_ready = 1; step(); step();

    // Backpressure: new instruction ignored until ex_ready rises.
    set_id(1, 2, 32'hA, 3, 32'hB, 32'hC, 1, 3'b000, 7, 1, 0);
    step();
    set_id(1, 5, 32'hD, 6, 32'hE, 32'hF, 0, 3'b001, 8, 0, 1);
    ex_ready = 0; step(); step();
    ex_ready = 1; step();
    id_valid = 0; step();

    // Flush coincident with accepting a branch.
    set_id(1, 1, 32'd4, 2, 32'd4, 32'd0, 0, 3'b001, 0, 1, 1);
    flush = 1; step();
    flush = 0; id_valid = 0; step();

    // Randomized traffic with frequent register-address collisions.
    for (int i = 0; i < 1500; i++) begin
      rst_n    = ($urandom_range(0, 99) >= 2);
      flush    = ($urandom_range(0, 99) < 8);
      ex_ready = ($urandom_range(0, 99) < 65);
      set_id($urandom_range(0, 99) < 75, 5'($urandom_range(0, 3)), $urandom,
             5'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      mem_rd_addr = 5'($urandom_range(0, 3)); mem_regwrite = 1'($urandom_range(0, 1));
      mem_result = $urandom;
      wb_rd_addr = 5'($urandom_range(0, 3)); wb_regwrite = 1'($urandom_range(0, 1));
      wb_result = $urandom;
      step();
    end

    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
